// File: rtl/mem_bist_ctrl.sv
// Built-in self-test initiator for a single-port memory: write 0s, read-check, write
// address pattern, read-check, with saturating error count and first-failure capture.
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [DATA_WIDTH-1:0] first_fail_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
        S_DRN0,
        S_WRA,
        S_RDA,
        S_DRN1,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam int                    LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [LAT_W-1:0]        lat_cnt;
    logic [LAT_W-1:0]        lat_nx;
    logic                    start_accept;
    logic                    mismatch;
    logic                    sticky;

    // Compare pipeline: one stage per cycle of read latency, tail lines up with data_out.
    logic                    pipe_vld  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp  [READ_LATENCY];

    function automatic logic [DATA_WIDTH-1:0] addr_pattern(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a);
    endfunction

    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        lat_nx       = lat_cnt;
        start_accept = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_nx     = S_WR0;
                    addr_nx      = '0;
                end
            end
            S_WR0, S_WRA: begin
                if (addr == ADDR_LAST) begin
                    state_nx = (state == S_WR0) ? S_RD0 : S_RDA;
                    addr_nx  = '0;
                end else begin
                    addr_nx = addr + ADDR_WIDTH'(1);
                end
            end
            S_RD0, S_RDA: begin
                if (addr == ADDR_LAST) begin
                    state_nx = (state == S_RD0) ? S_DRN0 : S_DRN1;
                    addr_nx  = '0;
                    lat_nx   = '0;
                end else begin
                    addr_nx = addr + ADDR_WIDTH'(1);
                end
            end
            S_DRN0, S_DRN1: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nx = (state == S_DRN0) ? S_WRA : S_DONE;
                    lat_nx   = '0;
                end else begin
                    lat_nx = lat_cnt + LAT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                addr_nx  = '0;
                lat_nx   = '0;
            end
        endcase
    end

    always_comb begin
        mismatch = pipe_vld[READ_LATENCY-1] && (data_out != pipe_exp[READ_LATENCY-1]);
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            addr            <= '0;
            lat_cnt         <= '0;
            read            <= 1'b0;
            write           <= 1'b0;
            data_in         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
            sticky          <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_exp[i]  <= '0;
            end
        end else begin
            state   <= state_nx;
            addr    <= addr_nx;
            lat_cnt <= lat_nx;
            write   <= (state_nx == S_WR0) || (state_nx == S_WRA);
            read    <= (state_nx == S_RD0) || (state_nx == S_RDA);
            data_in <= (state_nx == S_WRA) ? addr_pattern(addr_nx) : '0;
            busy    <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done    <= (state_nx == S_DONE);

            pipe_vld[0]  <= read;
            pipe_addr[0] <= addr;
            pipe_exp[0]  <= (state == S_RDA) ? addr_pattern(addr) : '0;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end

            if (start_accept) begin
                err_count       <= '0;
                first_fail_addr <= '0;
                first_fail_data <= '0;
                sticky          <= 1'b0;
                pass            <= 1'b0;
            end else begin
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                    if (!sticky) begin
                        first_fail_addr <= pipe_addr[READ_LATENCY-1];
                        first_fail_data <= data_out;
                    end
                    sticky <= 1'b1;
                end
                // The final drain compare lands on the same edge that enters DONE.
                pass <= (state_nx == S_DONE) && !(sticky || mismatch);
            end
        end
    end

endmodule
